i2c_txn_scheduler: RTL

Transaction sequencer and round-robin arbiter that shares one byte-level I2C master engine between `NREQ` requesters, such as the EDID reader and a register-config client. It turns each granted request into the full command sequence: START, device address, register address, then either a one-byte write or a repeated-start read of `len` bytes, and finally STOP. Read bytes stream back to the owner, and a completion status is reported. It sits between the clients and the I2C byte engine, in the `scl_4x` domain.

---
 rtl/i2c_txn_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_scheduler.sv
// Round-robin sequencer sharing one byte-level I2C master engine between NREQ clients.
// Each grant becomes START, device/register address, one write or a repeated-start read, then STOP.
module i2c_txn_scheduler #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 9
) (
    input  logic                    i_scl_4x,
    input  logic                    i_reset_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*7-1:0]       i_dev_addr,
    input  logic [NREQ*8-1:0]       i_reg_addr,
    input  logic [NREQ-1:0]         i_rw,
    input  logic [NREQ*8-1:0]       i_wr_data,
    input  logic [NREQ*LEN_W-1:0]   i_len,
    output logic [NREQ-1:0]         o_gnt,
    output logic [NREQ-1:0]         o_done,
    output logic [1:0]              o_err,
    output logic                    o_rd_valid,
    output logic [7:0]              o_rd_data,
    output logic                    o_rd_last,
    output logic                    o_cmd_valid,
    output logic [2:0]              o_cmd,
    output logic [7:0]              o_cmd_data,
    input  logic                    i_cmd_ready,
    input  logic                    i_eng_done,
    input  logic                    i_eng_ack,
    input  logic [7:0]              i_eng_rdata
);
    localparam int IDX_W = $clog2(NREQ);
    localparam logic [2:0] C_START = 3'd0, C_WRITE = 3'd1, C_RACK  = 3'd2,
                           C_RNACK = 3'd3, C_STOP  = 3'd4, C_RSTRT = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_REGA, S_WDATA, S_RSTRT, S_DEVR, S_RDB, S_STOP, S_FIN
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic [1:0]         r_err;
    logic               r_rd_valid;
    logic [7:0]         r_rd_data;
    logic               r_rd_last;
    logic               r_cmd_valid;
    logic [2:0]         r_cmd;
    logic [7:0]         r_cmd_data;
    logic               r_wait;
    logic [6:0]         r_dev;
    logic [7:0]         r_reg;
    logic               r_rw;
    logic [7:0]         r_wdata;
    logic [LEN_W-1:0]   r_len;

    logic               w_win_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_cand;

    // Walk from farthest to nearest so the requester right after last_gnt wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(r_last_gnt) + k) % NREQ);
            if (i_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge i_scl_4x or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_last_gnt  <= IDX_W'(NREQ - 1);
            r_owner     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 2'd0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 8'd0;
            r_rd_last   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= C_START;
            r_cmd_data  <= 8'd0;
            r_wait      <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_rw        <= 1'b0;
            r_wdata     <= 8'd0;
            r_len       <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            if (r_cmd_valid && i_cmd_ready) begin
                r_cmd_valid <= 1'b0;
                r_wait      <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_owner     <= w_win_idx;
                        r_gnt       <= NREQ'(1) << w_win_idx;
                        r_dev       <= i_dev_addr[int'(w_win_idx)*7 +: 7];
                        r_reg       <= i_reg_addr[int'(w_win_idx)*8 +: 8];
                        r_rw        <= i_rw[w_win_idx];
                        r_wdata     <= i_wr_data[int'(w_win_idx)*8 +: 8];
                        r_len       <= i_len[int'(w_win_idx)*LEN_W +: LEN_W];
                        r_err       <= 2'd0;
                        r_cmd       <= C_START;
                        r_cmd_data  <= 8'd0;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_FIN: begin
                    r_done     <= '0;
                    r_gnt      <= '0;
                    r_last_gnt <= r_owner;
                    r_state    <= S_IDLE;
                end
                default: begin
                    if (r_wait && i_eng_done) begin
                        // Every completion launches the next state's single command.
                        r_wait      <= 1'b0;
                        r_cmd_valid <= 1'b1;
                        r_cmd_data  <= 8'd0;
                        r_cmd       <= C_STOP;
                        r_state     <= S_STOP;
                        case (r_state)
                            S_START: begin
                                r_state    <= S_DEVW;
                                r_cmd      <= C_WRITE;
                                r_cmd_data <= {r_dev, 1'b0};
                            end
                            S_DEVW: begin
                                if (i_eng_ack) begin
                                    r_err <= 2'd1;
                                end else begin
                                    r_state    <= S_REGA;
                                    r_cmd      <= C_WRITE;
                                    r_cmd_data <= r_reg;
                                end
                            end
                            S_REGA: begin
                                if (i_eng_ack) begin
                                    r_err <= 2'd2;
                                end else if (!r_rw) begin
                                    r_state    <= S_WDATA;
                                    r_cmd      <= C_WRITE;
                                    r_cmd_data <= r_wdata;
                                end else if (r_len != '0) begin
                                    r_state <= S_RSTRT;
                                    r_cmd   <= C_RSTRT;
                                end
                            end
                            S_WDATA: begin
                                if (i_eng_ack) r_err <= 2'd3;
                            end
                            S_RSTRT: begin
                                r_state    <= S_DEVR;
                                r_cmd      <= C_WRITE;
                                r_cmd_data <= {r_dev, 1'b1};
                            end
                            S_DEVR: begin
                                if (i_eng_ack) begin
                                    r_err <= 2'd3;
                                end else begin
                                    r_state <= S_RDB;
                                    r_cmd   <= (r_len == LEN_W'(1)) ? C_RNACK : C_RACK;
                                end
                            end
                            S_RDB: begin
                                r_rd_valid <= 1'b1;
                                r_rd_data  <= i_eng_rdata;
                                r_rd_last  <= (r_len == LEN_W'(1));
                                r_len      <= r_len - LEN_W'(1);
                                if (r_len != LEN_W'(1)) begin
                                    r_state <= S_RDB;
                                    r_cmd   <= (r_len == LEN_W'(2)) ? C_RNACK : C_RACK;
                                end
                            end
                            S_STOP: begin
                                r_cmd_valid <= 1'b0;
                                r_done      <= r_gnt;
                                r_state     <= S_FIN;
                            end
                            default: begin
                                r_cmd_valid <= 1'b0;
                                r_state     <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_rd_last   = r_rd_last;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;
    assign o_cmd_data  = r_cmd_data;
endmodule
